// File: rtl/screen_pkg.sv
// Shared screen constants: frame geometry, RGB 4:4:4 field layout and the
// loader FSM state encoding.
package screen_pkg;

  localparam int unsigned NUM_PIXELS      = 4096;
  localparam int unsigned TOTAL_BIT_DEPTH = 12;
  localparam int unsigned CHAN_BITS       = 4;
  localparam int unsigned RED_LSB         = 8;
  localparam int unsigned GREEN_LSB       = 4;
  localparam int unsigned BLUE_LSB        = 0;

  typedef enum logic [2:0] {
    StIdle,
    StInitHi,
    StInitLo,
    StPushHi,
    StPushLo,
    StFillHi,
    StFillLo
  } state_t;

  // Packs separate channel values into a {R,G,B} pixel word.
  function automatic logic [TOTAL_BIT_DEPTH-1:0] pack_rgb(input logic [CHAN_BITS-1:0] r,
                                                          input logic [CHAN_BITS-1:0] g,
                                                          input logic [CHAN_BITS-1:0] b);
    logic [TOTAL_BIT_DEPTH-1:0] p;
    p = '0;
    p[RED_LSB +: CHAN_BITS]   = r;
    p[GREEN_LSB +: CHAN_BITS] = g;
    p[BLUE_LSB +: CHAN_BITS]  = b;
    return p;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO buffering CPU pixels ahead of the panel writer.
// Pointers carry one extra wrap bit to tell full from empty.
module loader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Flags and guarded push/pop; a full FIFO ignores pushes, an empty one ignores pops.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/screen_loader.sv
// Drives a strobe-addressed LED panel: streams CPU pixels from a FIFO, rewinds
// the panel address on request and performs full-frame colour fills.
module screen_loader #(
  parameter int unsigned NUM_PIXELS      = screen_pkg::NUM_PIXELS,
  parameter int unsigned TOTAL_BIT_DEPTH = screen_pkg::TOTAL_BIT_DEPTH,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_valid,
  input  logic [TOTAL_BIT_DEPTH-1:0]    cpu_pixel,
  output logic                          cpu_ready,
  input  logic                          frame_start,
  input  logic                          fill_start,
  input  logic [TOTAL_BIT_DEPTH-1:0]    fill_color,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_PIXELS)-1:0] pixel_count,
  output logic [31:0]                   mat_in,
  output logic                          wr_data,
  output logic                          init
);

  import screen_pkg::*;

  localparam int unsigned CW = $clog2(NUM_PIXELS);

  state_t                     state_q, state_d;
  logic                       pend_fill_q, pend_fill_d;
  logic                       pend_frame_q, pend_frame_d;
  logic                       is_fill_q;
  logic [TOTAL_BIT_DEPTH-1:0] fill_color_q;
  logic [TOTAL_BIT_DEPTH-1:0] mat_q;
  logic [CW-1:0]              pix_q;
  logic                       done_q;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [TOTAL_BIT_DEPTH-1:0] fifo_rdata;
  logic                       fifo_push;
  logic                       pop;
  logic                       take_fill;
  logic                       take_frame;
  logic                       dispatch;
  logic                       last_pix;

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TOTAL_BIT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (cpu_pixel),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake and status outputs; cpu_ready is forced low while reset is held.
  always_comb begin
    cpu_ready   = reset && !fifo_full;
    fifo_push   = cpu_valid && cpu_ready;
    last_pix    = (pix_q == CW'(NUM_PIXELS - 1));
    busy        = (state_q != StIdle) || pend_fill_q || pend_frame_q || !fifo_empty;
    done        = done_q;
    pixel_count = pix_q;
    mat_in      = 32'(mat_q);
    init        = (state_q == StInitHi);
    wr_data     = (state_q == StPushHi) || (state_q == StFillHi);
  end

  // Next-state logic. PUSH_LO re-dispatches like IDLE so queued pixels strobe every 2 cycles.
  always_comb begin
    state_d    = state_q;
    dispatch   = 1'b0;
    pop        = 1'b0;
    take_fill  = 1'b0;
    take_frame = 1'b0;
    unique case (state_q)
      StIdle:   dispatch = 1'b1;
      StInitHi: state_d = StInitLo;
      StInitLo: state_d = is_fill_q ? StFillHi : StIdle;
      StPushHi: state_d = StPushLo;
      StPushLo: begin
        state_d  = StIdle;
        dispatch = 1'b1;
      end
      StFillHi: state_d = StFillLo;
      StFillLo: state_d = last_pix ? StIdle : StFillHi;
      default:  state_d = StIdle;
    endcase
    if (dispatch) begin
      if (pend_fill_q) begin
        take_fill = 1'b1;
        state_d   = StInitHi;
      end else if (pend_frame_q) begin
        take_frame = 1'b1;
        state_d    = StInitHi;
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = StPushHi;
      end
    end
  end

  // Request latches; a fill implies its own init, so it swallows any frame request.
  always_comb begin
    pend_fill_d  = fill_start || (pend_fill_q && !take_fill);
    pend_frame_d = (frame_start && !fill_start) ||
                   (pend_frame_q && !take_frame && !take_fill);
  end

  // State, pending flags, pixel word, address counter and done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      pend_fill_q  <= 1'b0;
      pend_frame_q <= 1'b0;
      is_fill_q    <= 1'b0;
      fill_color_q <= '0;
      mat_q        <= '0;
      pix_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_fill_q  <= pend_fill_d;
      pend_frame_q <= pend_frame_d;
      if (fill_start) fill_color_q <= fill_color;
      if (take_fill) begin
        is_fill_q <= 1'b1;
        mat_q     <= fill_color_q;
      end else if (take_frame) begin
        is_fill_q <= 1'b0;
      end else if (pop) begin
        mat_q <= fifo_rdata;
      end
      if (state_q == StInitLo) begin
        pix_q <= '0;
      end else if (state_q == StPushLo || state_q == StFillLo) begin
        pix_q <= pix_q + 1'b1;
      end
      done_q <= (state_q == StFillLo) && last_pix;
    end
  end

endmodule
